pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter CNT_W, default 20, width of the measurement counters and results.
REQ-002 The block SHALL have parameter TIMEOUT, default 1_000_000, the number of consecutive slow_clk cycles without an input edge that declares the signal lost.
REQ-003 The block SHALL have port slow_clk  input  1  sampling and system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port pwm_in  input  1  PWM signal under measurement, asynchronous to slow_clk.
REQ-006 The block SHALL have port high_cnt  output  CNT_W  high time of the last complete period, in slow_clk cycles.
REQ-007 The block SHALL have port period_cnt  output  CNT_W  rise-to-rise time of the last complete period, in slow_clk cycles.
REQ-008 The block SHALL have port meas_valid  output  1  one-cycle pulse when high_cnt and period_cnt update.
REQ-009 The block SHALL have port signal_lost  output  1  level; no edge for TIMEOUT cycles.

Function
REQ-010 The block SHALL pass pwm_in through a 2-flop synchronizer (s) plus one history flop (p); rise = s & ~p, fall = ~s & p. Both edges SHALL have identical latency, so widths are exact in samples.
REQ-011 The FSM SHALL have states WAIT_RISE, MEAS_HIGH and MEAS_LOW, and SHALL enter WAIT_RISE on reset.
REQ-012 WAIT_RISE: on rise -> MEAS_HIGH; hcnt <= 1, pcnt <= 1; clear signal_lost. Otherwise hold.
REQ-013 MEAS_HIGH: no fall -> hcnt and pcnt increment. On fall -> MEAS_LOW; hlatch <= hcnt (no increment); pcnt increments.
REQ-014 MEAS_LOW: no rise -> pcnt increments. On rise -> high_cnt <= hlatch, period_cnt <= pcnt, meas_valid <= 1 for one cycle, hcnt <= 1, pcnt <= 1, -> MEAS_HIGH.
REQ-015 Outputs SHALL be registered: meas_valid and the new results SHALL be visible together in the cycle after the rise is detected.
REQ-016 A partial period after WAIT_RISE SHALL never produce meas_valid; the first valid SHALL require rise -> fall -> rise.
REQ-017 hcnt and pcnt SHALL saturate at 2^CNT_W-1 with no wrap; saturated values SHALL be reported as-is.
REQ-018 A timeout counter SHALL clear on any rise or fall and otherwise increment. On reaching TIMEOUT: signal_lost <= 1, high_cnt <= 0, period_cnt <= 0, FSM -> WAIT_RISE, no meas_valid.
REQ-019 signal_lost SHALL stay 1 until the next rise; constant 0% or 100% duty SHALL therefore report lost.
REQ-020 If an edge and timeout expiry coincide in one cycle, the edge SHALL win: timer clears and signal_lost is not set.
REQ-021 There SHALL be no glitch filtering; a one-sample high pulse SHALL measure as high_cnt = 1.
REQ-022 TIMEOUT counter width SHALL be sufficient to hold TIMEOUT with no overflow.

Reset
REQ-023 rst SHALL immediately (asynchronously) clear high_cnt, period_cnt, meas_valid, signal_lost, all counters and synchronizer flops, and set FSM to WAIT_RISE.
REQ-024 Reset mid-measurement SHALL discard the period in progress; results SHALL remain 0 until the first full period after release.

Verification (CNT_W=8, TIMEOUT=16 unless noted)
REQ-025 Steady 3 high / 5 low samples -> first meas_valid after the second rise: high_cnt=3, period_cnt=8; then a pulse every 8 cycles.
REQ-026 After a valid measurement, hold pwm_in=1 for 20 cycles -> signal_lost=1 and outputs 0 exactly 16 cycles after the last edge; the next rise clears signal_lost, with no meas_valid until rise -> fall -> rise.
REQ-027 TIMEOUT=1000, 10 high / 300 low -> high_cnt=10, period_cnt=255 (saturated).
REQ-028 Assert rst during MEAS_LOW -> all outputs 0 without a clock edge; after release, meas_valid only after the second rise.
REQ-029 1 high / 7 low -> high_cnt=1, period_cnt=8. Switch to 6 high / 2 low -> the first valid period after the switch reports high_cnt=6, period_cnt=8.

Source files
------------

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the high time and the rise-to-rise period of an asynchronous PWM
// signal in slow_clk cycles. The input is synchronized, edges are detected
// on the synchronized stream, and a small FSM counts samples between edges.
// A watchdog timer declares the signal lost when no edge arrives for
// TIMEOUT consecutive cycles; this also covers 0% and 100% duty.
//
// Parameters:
//   CNT_W    - width of the measurement counters and results
//   TIMEOUT  - edge-free cycles before signal_lost is raised
//
// Ports:
//   slow_clk    in   sampling / system clock, rising edge
//   rst         in   asynchronous active-high reset
//   pwm_in      in   PWM signal, asynchronous to slow_clk
//   high_cnt    out  high time of the last complete period
//   period_cnt  out  rise-to-rise time of the last complete period
//   meas_valid  out  one-cycle pulse when high_cnt/period_cnt update
//   signal_lost out  level, set after TIMEOUT edge-free cycles
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             slow_clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             signal_lost
);

    // Timer must be able to represent TIMEOUT itself, where it parks once
    // the signal has been declared lost.
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [TMR_W-1:0] tmr_q,    tmr_d;
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] hcnt_q,   hcnt_d;
    logic [CNT_W-1:0] pcnt_q,   pcnt_d;
    logic [CNT_W-1:0] hlatch_q, hlatch_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q,  valid_d;
    logic             lost_q,   lost_d;

    logic             rise;
    logic             fall;
    logic             edgeSeen;
    logic             timeout;
    logic [CNT_W-1:0] hInc;
    logic [CNT_W-1:0] pInc;

    // Two-flop synchronizer followed by a history flop. Both edges are
    // derived from the same pair of flops, so rise and fall see identical
    // latency and measured widths are exact in samples.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;
    assign edgeSeen = rise | fall;

    // An edge in the expiry cycle wins, so expiry is qualified by no edge.
    assign timeout  = ~edgeSeen & (tmr_q == TMR_LAST);

    // Saturating increments; a counter that has hit its maximum stays there.
    assign hInc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_ONE;
    assign pInc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;

    // Edge-free cycle counter. It parks at TIMEOUT so expiry fires only once
    // per quiet stretch.
    always_comb begin
        tmr_d = tmr_q;
        if (edgeSeen) begin
            tmr_d = '0;
        end else if (tmr_q != TMR_FULL) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    // Measurement FSM. The high time is latched at the fall and only
    // published at the following rise, together with the period, so a
    // result always describes one complete rise -> fall -> rise cycle.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        pcnt_d   = pcnt_q;
        hlatch_d = hlatch_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = 1'b0;
        lost_d   = lost_q;

        if (rise) begin
            lost_d = 1'b0;
        end

        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = MEAS_HIGH;
                    hcnt_d  = CNT_ONE;
                    pcnt_d  = CNT_ONE;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    state_d  = MEAS_LOW;
                    hlatch_d = hcnt_q;
                    pcnt_d   = pInc;
                end else begin
                    hcnt_d = hInc;
                    pcnt_d = pInc;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    state_d  = MEAS_HIGH;
                    high_d   = hlatch_q;
                    period_d = pcnt_q;
                    valid_d  = 1'b1;
                    hcnt_d   = CNT_ONE;
                    pcnt_d   = CNT_ONE;
                end else begin
                    pcnt_d = pInc;
                end
            end
            default: begin
                state_d = WAIT_RISE;
            end
        endcase

        // Loss of signal overrides everything; it can only fire in a cycle
        // with no edge, so no measurement is being published at the same time.
        if (timeout) begin
            state_d  = WAIT_RISE;
            lost_d   = 1'b1;
            high_d   = '0;
            period_d = '0;
            valid_d  = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            tmr_q    <= '0;
            state_q  <= WAIT_RISE;
            hcnt_q   <= '0;
            pcnt_q   <= '0;
            hlatch_q <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            tmr_q    <= tmr_d;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            pcnt_q   <= pcnt_d;
            hlatch_q <= hlatch_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
        end
    end

    assign high_cnt    = high_q;
    assign period_cnt  = period_q;
    assign meas_valid  = valid_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Scoreboard bench for pwm_capture. Instance A uses CNT_W=8, TIMEOUT=16;
// instance B uses CNT_W=8, TIMEOUT=1000 for the saturation case. Stimulus
// pushes expected {high, period} pairs into per-instance queues; monitors
// pop and compare whenever meas_valid pulses.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    logic       slowClk = 1'b0;
    logic       rst;
    logic       pwmA;
    logic       pwmB;
    logic [7:0] highA, periodA, highB, periodB;
    logic       validA, lostA, validB, lostB;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [15:0] expA[$];
    logic [15:0] expB[$];
    logic [15:0] eA;
    logic [15:0] eB;

    pwm_capture #(.CNT_W(8), .TIMEOUT(16)) dutA (
        .slow_clk    (slowClk),
        .rst         (rst),
        .pwm_in      (pwmA),
        .high_cnt    (highA),
        .period_cnt  (periodA),
        .meas_valid  (validA),
        .signal_lost (lostA)
    );

    pwm_capture #(.CNT_W(8), .TIMEOUT(1000)) dutB (
        .slow_clk    (slowClk),
        .rst         (rst),
        .pwm_in      (pwmB),
        .high_cnt    (highB),
        .period_cnt  (periodB),
        .meas_valid  (validB),
        .signal_lost (lostB)
    );

    always #5 slowClk = ~slowClk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushA(input logic [7:0] h, input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) expA.push_back({h, p});
    endtask

    // Drives n periods of h high / l low samples, one value per clock,
    // changing on the falling edge so the DUT samples mid-cycle.
    task automatic applyStimulus(input bit chanB, input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h + l; i++) begin
                if (chanB) pwmB = (i < h);
                else       pwmA = (i < h);
                @(negedge slowClk);
            end
        end
    endtask

    // Scoreboard monitor for instance A.
    always @(posedge slowClk) begin
        #1;
        if (validA === 1'b1) begin
            if (expA.size() == 0) begin
                checkOutput("spuriousValidA", 32'(validA), 32'd0);
            end else begin
                eA = expA.pop_front();
                checkOutput("highA", 32'(highA), 32'(eA[15:8]));
                checkOutput("periodA", 32'(periodA), 32'(eA[7:0]));
            end
        end
    end

    // Scoreboard monitor for instance B.
    always @(posedge slowClk) begin
        #1;
        if (validB === 1'b1) begin
            if (expB.size() == 0) begin
                checkOutput("spuriousValidB", 32'(validB), 32'd0);
            end else begin
                eB = expB.pop_front();
                checkOutput("highB", 32'(highB), 32'(eB[15:8]));
                checkOutput("periodB", 32'(periodB), 32'(eB[7:0]));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        bit seen;
        rst  = 1'b0;
        pwmA = 1'b0;
        pwmB = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("resetHighA", 32'(highA), 32'd0);
        checkOutput("resetPeriodA", 32'(periodA), 32'd0);
        checkOutput("resetValidA", 32'(validA), 32'd0);
        checkOutput("resetLostA", 32'(lostA), 32'd0);
        checkOutput("resetLostB", 32'(lostB), 32'd0);
        repeat (3) @(negedge slowClk);
        rst = 1'b0;

        // Constant low input is reported as lost.
        repeat (20) @(negedge slowClk);
        checkOutput("lostOnConstantLow", 32'(lostA), 32'd1);

        // Steady 3 high / 5 low: first result at the second rise.
        pushA(8'd3, 8'd8, 3);
        applyStimulus(1'b0, 3, 5, 4);
        checkOutput("lostClearedByRise", 32'(lostA), 32'd0);

        // Hold high: the rise publishes one more result, then loss after
        // exactly 16 edge-free cycles.
        pushA(8'd3, 8'd8, 1);
        pwmA = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge slowClk);
            #1;
            if (validA === 1'b1) seen = 1'b1;
        end
        checkOutput("validBeforeHold", 32'(seen), 32'd1);
        repeat (15) @(posedge slowClk);
        #1;
        checkOutput("lostAt15", 32'(lostA), 32'd0);
        @(posedge slowClk);
        #1;
        checkOutput("lostAt16", 32'(lostA), 32'd1);
        checkOutput("lostHighZero", 32'(highA), 32'd0);
        checkOutput("lostPeriodZero", 32'(periodA), 32'd0);
        @(negedge slowClk);
        pwmA = 1'b0;
        repeat (6) @(negedge slowClk);
        checkOutput("lostHeldAfterFall", 32'(lostA), 32'd1);

        // Recovery: partial period first, so only two results from three.
        pushA(8'd3, 8'd8, 2);
        applyStimulus(1'b0, 3, 5, 3);
        checkOutput("lostClearedAgain", 32'(lostA), 32'd0);
        repeat (20) @(negedge slowClk);

        // Fall lands exactly in the expiry cycle: the edge must win.
        pushA(8'd16, 8'd20, 2);
        applyStimulus(1'b0, 16, 4, 3);
        checkOutput("edgeWinsNoLost", 32'(lostA), 32'd0);
        repeat (20) @(negedge slowClk);

        // One-sample pulse, then duty switch without a gap.
        pushA(8'd1, 8'd8, 3);
        pushA(8'd6, 8'd8, 2);
        applyStimulus(1'b0, 1, 7, 3);
        applyStimulus(1'b0, 6, 2, 3);
        repeat (20) @(negedge slowClk);

        // Reset in the middle of the low phase.
        pushA(8'd3, 8'd8, 2);
        applyStimulus(1'b0, 3, 5, 2);
        applyStimulus(1'b0, 3, 2, 1);
        checkOutput("highBeforeReset", 32'(highA), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstHigh", 32'(highA), 32'd0);
        checkOutput("asyncRstPeriod", 32'(periodA), 32'd0);
        checkOutput("asyncRstValid", 32'(validA), 32'd0);
        checkOutput("asyncRstLost", 32'(lostA), 32'd0);
        @(negedge slowClk);
        rst = 1'b0;
        applyStimulus(1'b0, 3, 5, 1);
        checkOutput("partialHighZero", 32'(highA), 32'd0);
        checkOutput("partialPeriodZero", 32'(periodA), 32'd0);
        pushA(8'd3, 8'd8, 2);
        applyStimulus(1'b0, 3, 5, 2);
        repeat (5) @(negedge slowClk);

        // Long low time saturates the period counter.
        expB.push_back({8'd10, 8'd255});
        applyStimulus(1'b1, 10, 300, 2);
        repeat (5) @(negedge slowClk);

        checkOutput("pendingA", 32'(expA.size()), 32'd0);
        checkOutput("pendingB", 32'(expB.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
